// File: rtl/reg_access_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_seq_pkg
// Purpose  : Shared constants for the register-access sequencer: word and
//            select widths, legal select ranges, FSM state encodings, named
//            register selects, and the half-word masking helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reg_access_seq_pkg;

   localparam int DATA_W    = 20;
   localparam int HALF_W    = DATA_W / 2;
   localparam int SEL_W     = 4;
   localparam int FULL_REGS = 6;
   localparam int HALF_REGS = 12;

   // FSM state encodings
   typedef logic [2:0] state_t;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD_A = 3'd1;
   localparam logic [2:0] S_RD_B = 3'd2;
   localparam logic [2:0] S_CAP  = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] S_WR   = 3'd5;

   // Full-word register selects
   localparam logic [SEL_W-1:0] AX = 4'd0;
   localparam logic [SEL_W-1:0] BX = 4'd1;
   localparam logic [SEL_W-1:0] CX = 4'd2;
   localparam logic [SEL_W-1:0] DX = 4'd3;
   localparam logic [SEL_W-1:0] EX = 4'd4;
   localparam logic [SEL_W-1:0] FX = 4'd5;

   // Half-word register selects: even = low half, odd = high half
   localparam logic [SEL_W-1:0] AXL = 4'd0;
   localparam logic [SEL_W-1:0] AXH = 4'd1;
   localparam logic [SEL_W-1:0] BXL = 4'd2;
   localparam logic [SEL_W-1:0] BXH = 4'd3;
   localparam logic [SEL_W-1:0] CXL = 4'd4;
   localparam logic [SEL_W-1:0] CXH = 4'd5;
   localparam logic [SEL_W-1:0] DXL = 4'd6;
   localparam logic [SEL_W-1:0] DXH = 4'd7;
   localparam logic [SEL_W-1:0] EXL = 4'd8;
   localparam logic [SEL_W-1:0] EXH = 4'd9;
   localparam logic [SEL_W-1:0] FXL = 4'd10;
   localparam logic [SEL_W-1:0] FXH = 4'd11;

   // Half-word values only ever occupy the low half of the bus; the upper
   // half is forced to zero so stale or mirrored bits never leak through.
   function automatic logic [DATA_W-1:0] half_mask(input logic [DATA_W-1:0] data,
                                                   input logic              half);
      return half ? {{(DATA_W-HALF_W){1'b0}}, data[HALF_W-1:0]} : data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_access_seq_rf_sel_check.sv
`default_nettype none
// ============================================================================
// Module   : rf_sel_check
// Purpose  : Combinational legality check of a register-file select for
//            either full-word or half-word access.
// Ports    : sel      in  SEL_W  register select
//            half     in  1      1 = half-word addressing
//            in_range out 1      select addresses an existing register
// Revision : 1.0 - initial release
// ============================================================================
module rf_sel_check
   import reg_access_seq_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   input  logic             half,
   output logic             in_range
);

   assign in_range = half ? (sel < SEL_W'(HALF_REGS)) : (sel < SEL_W'(FULL_REGS));

endmodule
`default_nettype wire

// File: rtl/reg_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_seq
// Purpose  : Initiator of the GP register-file port. Sequences operand
//            reads for decode requests, presents operands to the ALU over
//            valid/ready, and retires ALU writebacks as register writes.
// Ports    : clk, reset (async, active low)
//            req_*   : operand-fetch request from decode
//            opnd_*  : operand hand-off to the ALU
//            wb_*    : writeback from the ALU
//            rf_*    : register-file control/data pins (all registered)
//            sel_err : one-cycle pulse when an illegal select is seen
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_seq
   import reg_access_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [SEL_W-1:0]  req_src_a,
   input  logic [SEL_W-1:0]  req_src_b,
   input  logic              req_two_src,
   input  logic              req_half,
   output logic              opnd_valid,
   input  logic              opnd_ready,
   output logic [DATA_W-1:0] opnd_a,
   output logic [DATA_W-1:0] opnd_b,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [SEL_W-1:0]  wb_dr,
   input  logic              wb_half,
   input  logic [DATA_W-1:0] wb_data,
   output logic              rf_readsig,
   output logic              rf_writesig,
   output logic              rf_halfword,
   output logic [SEL_W-1:0]  rf_sr,
   output logic [SEL_W-1:0]  rf_dr,
   output logic [DATA_W-1:0] rf_data_write,
   input  logic [DATA_W-1:0] rf_data_read,
   output logic              sel_err
);

   state_t            r_state;
   logic [SEL_W-1:0]  r_src_b;
   logic              r_two_src;
   logic              r_half;
   logic              r_a_ok;
   logic              r_b_ok;
   logic              r_opnd_valid;
   logic [DATA_W-1:0] r_opnd_a;
   logic [DATA_W-1:0] r_opnd_b;
   logic              r_sel_err;
   logic              r_rf_readsig;
   logic              r_rf_writesig;
   logic              r_rf_halfword;
   logic [SEL_W-1:0]  r_rf_sr;
   logic [SEL_W-1:0]  r_rf_dr;
   logic [DATA_W-1:0] r_rf_data_write;

   logic              w_idle;
   logic              w_wb_take;
   logic              w_req_take;
   logic              w_opnd_done;
   logic [SEL_W-1:0]  w_rd_sel;
   logic              w_rd_half;
   logic              w_rd_ok;
   logic              w_wr_ok;

   assign w_idle      = (r_state == S_IDLE);
   // Writebacks win over fetch requests so a read issued afterwards always
   // sees the freshly written value.
   assign w_wb_take   = wb_valid && (w_idle || (r_state == S_OUT));
   assign w_req_take  = w_idle && !wb_valid && req_valid;
   assign w_opnd_done = r_opnd_valid && opnd_ready;

   // The read checker serves source A while idle and source B during RD_A.
   assign w_rd_sel  = w_idle ? req_src_a : r_src_b;
   assign w_rd_half = w_idle ? req_half  : r_half;

   rf_sel_check u_rd_check (
      .sel      (w_rd_sel),
      .half     (w_rd_half),
      .in_range (w_rd_ok)
   );

   rf_sel_check u_wr_check (
      .sel      (wb_dr),
      .half     (wb_half),
      .in_range (w_wr_ok)
   );

   // Handshake outputs are gated by reset so every output is 0 while held.
   assign req_ready = reset && w_idle && !wb_valid;
   assign wb_ready  = reset && w_wb_take;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_src_b         <= '0;
         r_two_src       <= 1'b0;
         r_half          <= 1'b0;
         r_a_ok          <= 1'b0;
         r_b_ok          <= 1'b0;
         r_opnd_valid    <= 1'b0;
         r_opnd_a        <= '0;
         r_opnd_b        <= '0;
         r_sel_err       <= 1'b0;
         r_rf_readsig    <= 1'b0;
         r_rf_writesig   <= 1'b0;
         r_rf_halfword   <= 1'b0;
         r_rf_sr         <= '0;
         r_rf_dr         <= '0;
         r_rf_data_write <= '0;
      end else begin
         // Strobes and the error flag are single-cycle unless re-armed below.
         r_rf_readsig  <= 1'b0;
         r_rf_writesig <= 1'b0;
         r_sel_err     <= 1'b0;

         if (w_opnd_done) begin
            r_opnd_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_req_take) begin
                  r_src_b       <= req_src_b;
                  r_two_src     <= req_two_src;
                  r_half        <= req_half;
                  r_a_ok        <= w_rd_ok;
                  r_b_ok        <= 1'b0;
                  r_opnd_b      <= '0;
                  r_rf_readsig  <= w_rd_ok;
                  r_rf_sr       <= req_src_a;
                  r_rf_halfword <= req_half;
                  r_sel_err     <= !w_rd_ok;
                  r_state       <= S_RD_A;
               end
            end
            S_RD_A: begin
               if (r_two_src) begin
                  r_rf_readsig <= w_rd_ok;
                  r_rf_sr      <= r_src_b;
                  r_b_ok       <= w_rd_ok;
                  r_sel_err    <= !w_rd_ok;
               end
               r_state <= S_RD_B;
            end
            S_RD_B: begin
               // data_read now holds the A data registered at the end of RD_A.
               r_opnd_a <= r_a_ok ? half_mask(rf_data_read, r_half) : '0;
               if (r_two_src) begin
                  r_state <= S_CAP;
               end else begin
                  r_opnd_valid <= 1'b1;
                  r_state      <= S_OUT;
               end
            end
            S_CAP: begin
               r_opnd_b     <= r_b_ok ? half_mask(rf_data_read, r_half) : '0;
               r_opnd_valid <= 1'b1;
               r_state      <= S_OUT;
            end
            S_OUT: begin
               if (!wb_valid && w_opnd_done) begin
                  r_state <= S_IDLE;
               end
            end
            S_WR: begin
               // Return to OUT only if the ALU has still not taken the operands.
               r_state <= (r_opnd_valid && !opnd_ready) ? S_OUT : S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Accepted writeback: an illegal select keeps writesig low but the
         // WR cycle is still spent so the timing seen by the ALU is uniform.
         if (w_wb_take) begin
            r_rf_writesig   <= w_wr_ok;
            r_rf_dr         <= wb_dr;
            r_rf_halfword   <= wb_half;
            r_rf_data_write <= half_mask(wb_data, wb_half);
            r_sel_err       <= !w_wr_ok;
            r_state         <= S_WR;
         end
      end
   end

   assign opnd_valid    = r_opnd_valid;
   assign opnd_a        = r_opnd_a;
   assign opnd_b        = r_opnd_b;
   assign sel_err       = r_sel_err;
   assign rf_readsig    = r_rf_readsig;
   assign rf_writesig   = r_rf_writesig;
   assign rf_halfword   = r_rf_halfword;
   assign rf_sr         = r_rf_sr;
   assign rf_dr         = r_rf_dr;
   assign rf_data_write = r_rf_data_write;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_access_seq
// Purpose  : Directed self-checking bench for reg_access_seq with a small
//            behavioural register file attached to the rf_* pins.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_access_seq;
   import reg_access_seq_pkg::*;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [SEL_W-1:0]  req_src_a;
   logic [SEL_W-1:0]  req_src_b;
   logic              req_two_src;
   logic              req_half;
   logic              opnd_valid;
   logic              opnd_ready;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;
   logic              wb_valid;
   logic              wb_ready;
   logic [SEL_W-1:0]  wb_dr;
   logic              wb_half;
   logic [DATA_W-1:0] wb_data;
   logic              rf_readsig;
   logic              rf_writesig;
   logic              rf_halfword;
   logic [SEL_W-1:0]  rf_sr;
   logic [SEL_W-1:0]  rf_dr;
   logic [DATA_W-1:0] rf_data_write;
   logic [DATA_W-1:0] rf_data_read;
   logic              sel_err;

   int n_pass  = 0;
   int n_total = 0;
   int cnt_rd  = 0;
   int cnt_wr  = 0;
   int n_both  = 0;

   logic [74:0] all_out;
   assign all_out = {req_ready, wb_ready, opnd_valid, opnd_a, opnd_b, rf_readsig,
                     rf_writesig, rf_halfword, rf_sr, rf_dr, rf_data_write, sel_err};

   reg_access_seq dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_src_a     (req_src_a),
      .req_src_b     (req_src_b),
      .req_two_src   (req_two_src),
      .req_half      (req_half),
      .opnd_valid    (opnd_valid),
      .opnd_ready    (opnd_ready),
      .opnd_a        (opnd_a),
      .opnd_b        (opnd_b),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_dr         (wb_dr),
      .wb_half       (wb_half),
      .wb_data       (wb_data),
      .rf_readsig    (rf_readsig),
      .rf_writesig   (rf_writesig),
      .rf_halfword   (rf_halfword),
      .rf_sr         (rf_sr),
      .rf_dr         (rf_dr),
      .rf_data_write (rf_data_write),
      .rf_data_read  (rf_data_read),
      .sel_err       (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: data_read is registered on the edge that samples
   // readsig/sr. Half reads mirror the half into both halves of the bus.
   logic [DATA_W-1:0] rf_mem [FULL_REGS] = '{default: '0};
   logic [HALF_W-1:0] m_half;
   int                m_idx;
   initial rf_data_read = '0;

   always @(posedge clk) begin
      if (rf_writesig) begin
         if (rf_halfword) begin
            m_idx = int'(rf_dr) / 2;
            if (m_idx < FULL_REGS) begin
               if (rf_dr[0]) rf_mem[m_idx][DATA_W-1:HALF_W] <= rf_data_write[HALF_W-1:0];
               else          rf_mem[m_idx][HALF_W-1:0]      <= rf_data_write[HALF_W-1:0];
            end
         end else if (int'(rf_dr) < FULL_REGS) begin
            rf_mem[int'(rf_dr)] <= rf_data_write;
         end
      end
      if (rf_readsig) begin
         if (rf_halfword) begin
            m_idx = int'(rf_sr) / 2;
            if (m_idx < FULL_REGS) begin
               m_half = rf_sr[0] ? rf_mem[m_idx][DATA_W-1:HALF_W] : rf_mem[m_idx][HALF_W-1:0];
               rf_data_read <= {m_half, m_half};
            end else begin
               rf_data_read <= 20'hBAD00;
            end
         end else if (int'(rf_sr) < FULL_REGS) begin
            rf_data_read <= rf_mem[int'(rf_sr)];
         end else begin
            rf_data_read <= 20'hBAD00;
         end
      end
   end

   // Strobe monitor: counts cycles each strobe was high.
   always @(posedge clk) begin
      if (rf_readsig)                cnt_rd = cnt_rd + 1;
      if (rf_writesig)               cnt_wr = cnt_wr + 1;
      if (rf_readsig && rf_writesig) n_both = n_both + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_req(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b,
                            input logic two, input logic half);
      req_src_a   = a;
      req_src_b   = b;
      req_two_src = two;
      req_half    = half;
      req_valid   = 1'b1;
      #1;
      for (int i = 0; i < 20 && !req_ready; i++) begin
         tick();
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drive_write(input logic [SEL_W-1:0] dr, input logic half,
                              input logic [DATA_W-1:0] data);
      wb_dr    = dr;
      wb_half  = half;
      wb_data  = data;
      wb_valid = 1'b1;
      #1;
      for (int i = 0; i < 20 && !wb_ready; i++) begin
         tick();
      end
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   // Edges counted from the request handshake edge until opnd_valid; -1 on timeout.
   task automatic wait_opnd(output int lat);
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (opnd_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic consume();
      opnd_ready = 1'b1;
      tick();
      opnd_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = 1'b0; req_src_a = '0; req_src_b = '0; req_two_src = 1'b0; req_half = 1'b0;
      opnd_ready = 1'b0; wb_valid = 1'b0; wb_dr = '0; wb_half = 1'b0; wb_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL reset_idle_req_ready: got %b expected 1", req_ready);
      else n_pass++;
   endtask

   task automatic test_write_read();
      int lat;
      tick();
      wb_dr = AX; wb_half = 1'b0; wb_data = 20'h12345; wb_valid = 1'b1;
      #1;
      n_total++;
      if ({wb_ready, req_ready} !== 2'b10) $display("FAIL wr_accept: got %b expected 10", {wb_ready, req_ready});
      else n_pass++;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      n_total++;
      if ({rf_writesig, rf_readsig, rf_halfword, rf_dr, rf_data_write} !== {3'b100, 4'd0, 20'h12345})
         $display("FAIL wr_pins: got %b %b %b %h %h expected 1 0 0 0 12345",
                  rf_writesig, rf_readsig, rf_halfword, rf_dr, rf_data_write);
      else n_pass++;
      tick();
      issue_req(AX, AX, 1'b1, 1'b0);
      n_total++;
      if ({rf_readsig, rf_sr, rf_halfword} !== {1'b1, 4'd0, 1'b0})
         $display("FAIL rd_a_pins: got %b %h %b expected 1 0 0", rf_readsig, rf_sr, rf_halfword);
      else n_pass++;
      wait_opnd(lat);
      n_total++;
      if (lat !== 3) $display("FAIL two_src_latency: got %0d expected 3", lat);
      else n_pass++;
      n_total++;
      if ({opnd_a, opnd_b} !== {20'h12345, 20'h12345})
         $display("FAIL two_src_data: got %h %h expected 12345 12345", opnd_a, opnd_b);
      else n_pass++;
      consume();
      n_total++;
      if ({opnd_valid, req_ready} !== 2'b01)
         $display("FAIL consume_to_idle: got %b expected 01", {opnd_valid, req_ready});
      else n_pass++;
   endtask

   task automatic test_half_word();
      int lat;
      drive_write(BXH, 1'b1, 20'hFF2AB);
      n_total++;
      if ({rf_writesig, rf_halfword, rf_dr, rf_data_write} !== {2'b11, 4'd3, 20'h002AB})
         $display("FAIL half_wr_pins: got %b %b %h %h expected 1 1 3 002ab",
                  rf_writesig, rf_halfword, rf_dr, rf_data_write);
      else n_pass++;
      tick();
      issue_req(BXH, AX, 1'b0, 1'b1);
      wait_opnd(lat);
      n_total++;
      if (lat !== 2) $display("FAIL one_src_latency: got %0d expected 2", lat);
      else n_pass++;
      n_total++;
      if ({opnd_a, opnd_b} !== {20'h002AB, 20'h00000})
         $display("FAIL half_rd_data: got %h %h expected 002ab 00000", opnd_a, opnd_b);
      else n_pass++;
      consume();
      issue_req(BX, AX, 1'b0, 1'b0);
      wait_opnd(lat);
      n_total++;
      if (opnd_a !== 20'hAAC00) $display("FAIL half_wr_placement: got %h expected aac00", opnd_a);
      else n_pass++;
      consume();
   endtask

   task automatic test_simultaneous();
      int lat;
      wb_dr = CX; wb_half = 1'b0; wb_data = 20'h0BEEF; wb_valid = 1'b1;
      req_src_a = CX; req_src_b = AX; req_two_src = 1'b0; req_half = 1'b0; req_valid = 1'b1;
      #1;
      n_total++;
      if ({wb_ready, req_ready} !== 2'b10) $display("FAIL simul_priority: got %b expected 10", {wb_ready, req_ready});
      else n_pass++;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      n_total++;
      if ({rf_writesig, req_ready} !== 2'b10) $display("FAIL simul_wr_cycle: got %b expected 10", {rf_writesig, req_ready});
      else n_pass++;
      tick();
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL simul_req_ready: got %b expected 1", req_ready);
      else n_pass++;
      tick();
      req_valid = 1'b0;
      wait_opnd(lat);
      n_total++;
      if ({opnd_a, lat} !== {20'h0BEEF, 32'd2}) $display("FAIL simul_raw: got %h lat %0d expected 0beef lat 2", opnd_a, lat);
      else n_pass++;
      consume();
   endtask

   task automatic test_out_of_range();
      int lat;
      int base_rd;
      int base_wr;
      base_rd = cnt_rd;
      issue_req(4'd6, AX, 1'b0, 1'b0);
      n_total++;
      if ({rf_readsig, sel_err} !== 2'b01) $display("FAIL oor_full_rd_a: got %b expected 01", {rf_readsig, sel_err});
      else n_pass++;
      wait_opnd(lat);
      n_total++;
      if ({opnd_a, opnd_b, lat} !== {40'h0, 32'd2}) $display("FAIL oor_full_data: got %h %h lat %0d expected 0 0 lat 2", opnd_a, opnd_b, lat);
      else n_pass++;
      consume();
      n_total++;
      if (cnt_rd - base_rd !== 0) $display("FAIL oor_no_readsig: got %0d expected 0", cnt_rd - base_rd);
      else n_pass++;
      issue_req(AXL, 4'd12, 1'b1, 1'b1);
      n_total++;
      if ({rf_readsig, sel_err} !== 2'b10) $display("FAIL oor_half_rd_a: got %b expected 10", {rf_readsig, sel_err});
      else n_pass++;
      tick();
      n_total++;
      if ({rf_readsig, sel_err} !== 2'b01) $display("FAIL oor_half_rd_b: got %b expected 01", {rf_readsig, sel_err});
      else n_pass++;
      wait_opnd(lat);
      n_total++;
      if ({opnd_a, opnd_b, lat} !== {20'h00345, 20'h0, 32'd2}) $display("FAIL oor_half_data: got %h %h lat %0d expected 00345 0 lat 2", opnd_a, opnd_b, lat);
      else n_pass++;
      consume();
      base_wr = cnt_wr;
      drive_write(4'd12, 1'b1, 20'h00155);
      n_total++;
      if ({rf_writesig, sel_err} !== 2'b01) $display("FAIL oor_wr_pins: got %b expected 01", {rf_writesig, sel_err});
      else n_pass++;
      tick();
      n_total++;
      if ({cnt_wr - base_wr, sel_err, req_ready} !== {32'd0, 2'b01})
         $display("FAIL oor_wr_dropped: got %0d %b %b expected 0 0 1", cnt_wr - base_wr, sel_err, req_ready);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int   lat;
      logic stable;
      issue_req(AX, CX, 1'b1, 1'b0);
      wait_opnd(lat);
      n_total++;
      if ({opnd_a, opnd_b, lat} !== {20'h12345, 20'h0BEEF, 32'd3}) $display("FAIL bp_initial: got %h %h lat %0d expected 12345 0beef lat 3", opnd_a, opnd_b, lat);
      else n_pass++;
      stable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (opnd_valid !== 1'b1 || opnd_a !== 20'h12345 || opnd_b !== 20'h0BEEF) stable = 1'b0;
      end
      wb_dr = EX; wb_half = 1'b0; wb_data = 20'h0CAFE; wb_valid = 1'b1;
      #1;
      n_total++;
      if (wb_ready !== 1'b1) $display("FAIL bp_wb_ready: got %b expected 1", wb_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      n_total++;
      if ({rf_writesig, opnd_valid, opnd_a, opnd_b} !== {2'b11, 20'h12345, 20'h0BEEF})
         $display("FAIL bp_wr_during_stall: got %b %b %h %h expected 1 1 12345 0beef", rf_writesig, opnd_valid, opnd_a, opnd_b);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (opnd_valid !== 1'b1 || opnd_a !== 20'h12345 || opnd_b !== 20'h0BEEF || req_ready !== 1'b0) stable = 1'b0;
      end
      n_total++;
      if (stable !== 1'b1) $display("FAIL bp_stable: got %b expected 1", stable);
      else n_pass++;
      consume();
      n_total++;
      if ({opnd_valid, req_ready} !== 2'b01) $display("FAIL bp_release: got %b expected 01", {opnd_valid, req_ready});
      else n_pass++;
      issue_req(EX, AX, 1'b0, 1'b0);
      wait_opnd(lat);
      n_total++;
      if (opnd_a !== 20'h0CAFE) $display("FAIL bp_wb_retired: got %h expected 0cafe", opnd_a);
      else n_pass++;
      consume();
   endtask

   task automatic test_reset_mid_op();
      int base_wr;
      issue_req(AX, CX, 1'b1, 1'b0);
      tick();
      n_total++;
      if ({rf_readsig, rf_sr} !== {1'b1, 4'd2}) $display("FAIL rst_rd_b_state: got %b %h expected 1 2", rf_readsig, rf_sr);
      else n_pass++;
      base_wr = cnt_wr;
      reset = 1'b0;
      #1;
      n_total++;
      if (all_out !== '0) $display("FAIL rst_async_outputs: got %h expected 0", all_out);
      else n_pass++;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) tick();
      n_total++;
      if ({cnt_wr - base_wr, req_ready, opnd_valid} !== {32'd0, 2'b10})
         $display("FAIL rst_after_release: got %0d %b %b expected 0 1 0", cnt_wr - base_wr, req_ready, opnd_valid);
      else n_pass++;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_half_word();
      test_simultaneous();
      test_out_of_range();
      test_backpressure();
      test_reset_mid_op();
      n_total++;
      if (n_both !== 0) $display("FAIL strobe_exclusive: got %0d expected 0", n_both);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
